// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM encoding and default word width.
package serdes_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serializer_pipe_if.sv
// Word-side handshake and serial-side outputs of the serializer, bundled for port connection.
interface serializer_pipe_if import serdes_pkg::*; #(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              enable;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              msb_first;
  logic              dout;
  logic              dout_valid;
  logic              frame_start;
  logic              underrun;

  modport master (
    output enable, din, din_valid, msb_first,
    input  din_ready, dout, dout_valid, frame_start, underrun
  );

  modport slave (
    input  enable, din, din_valid, msb_first,
    output din_ready, dout, dout_valid, frame_start, underrun
  );

endinterface

// File: rtl/ser_bit_mux.sv
// DATA_W-to-1 bit selector: picks bit idx counted from the MSB (ord=1) or from the LSB (ord=0).
module ser_bit_mux #(
  parameter  int DATA_W = 16,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  input  logic              ord,
  output logic              dout
);

  logic [DATA_W-1:0] reversed;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign reversed[gi] = word[DATA_W-1-gi];
    end
  endgenerate

  assign dout = ord ? reversed[idx] : word[idx];

endmodule

// File: rtl/serializer_pipe.sv
// Parallel-to-serial converter with a one-word holding buffer; words stream gaplessly at one bit per clock.
module serializer_pipe import serdes_pkg::*; #(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  serializer_pipe_if.slave bus
);

  localparam int              IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [DATA_W-1:0]  hold_reg, hold_next;
  logic               hold_ord_reg, hold_ord_next;
  logic               hold_full_reg, hold_full_next;
  logic [DATA_W-1:0]  active_reg, active_next;
  logic               ord_reg, ord_next;
  logic               underrun_reg, underrun_next;

  logic last_bit;
  logic load;
  logic accept;
  logic mux_bit;

  // A new word may be moved into the shifter when the shifter is idle or on its last bit.
  assign last_bit      = (state_reg == ST_SHIFT) && (idx_reg == LAST_IDX);
  assign load          = ((state_reg == ST_IDLE) || last_bit) && bus.enable && hold_full_reg;
  assign bus.din_ready = !hold_full_reg || load;
  assign accept        = bus.din_valid && bus.din_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      hold_reg      <= '0;
      hold_ord_reg  <= 1'b0;
      hold_full_reg <= 1'b0;
      active_reg    <= '0;
      ord_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      hold_reg      <= hold_next;
      hold_ord_reg  <= hold_ord_next;
      hold_full_reg <= hold_full_next;
      active_reg    <= active_next;
      ord_reg       <= ord_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    hold_next      = hold_reg;
    hold_ord_next  = hold_ord_reg;
    active_next    = active_reg;
    ord_next       = ord_reg;
    underrun_next  = last_bit && bus.enable && !hold_full_reg;
    // Consume and refill in the same cycle keeps the buffer full with the new word.
    hold_full_next = accept || (hold_full_reg && !load);

    if (accept) begin
      hold_next     = bus.din;
      hold_ord_next = bus.msb_first;
    end

    if (load) begin
      state_next  = ST_SHIFT;
      active_next = hold_reg;
      ord_next    = hold_ord_reg;
      idx_next    = '0;
    end else begin
      case (state_reg)
        ST_SHIFT: begin
          if (last_bit) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  ser_bit_mux #(.DATA_W(DATA_W)) u_mux (
    .word (active_reg),
    .idx  (idx_reg),
    .ord  (ord_reg),
    .dout (mux_bit)
  );

  assign bus.dout_valid  = (state_reg == ST_SHIFT);
  assign bus.dout        = (state_reg == ST_SHIFT) && mux_bit;
  assign bus.frame_start = (state_reg == ST_SHIFT) && (idx_reg == '0);
  assign bus.underrun    = underrun_reg;

endmodule

// File: tb/tb_serializer_pipe.sv
// Drives three serializer widths (16, 8, 5) with shared directed stimulus; each is checked every cycle against a queue model.
module tb_serializer_pipe;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        enable    = 1'b0;
  logic [63:0] stim_din  = '0;
  logic        din_valid = 1'b0;
  logic        msb_first = 1'b0;

  int compare_count  = 0;
  int mismatch_count = 0;

  logic tap_valid [3];
  logic tap_dout  [3];
  logic tap_fs    [3];
  logic tap_und   [3];
  logic tap_ready [3];

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compare_count++;
    if (act !== exp) begin
      mismatch_count++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_w
      localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : 5;

      serializer_pipe_if #(.DATA_W(W)) bus ();

      assign bus.enable    = enable;
      assign bus.din       = stim_din[W-1:0];
      assign bus.din_valid = din_valid;
      assign bus.msb_first = msb_first;

      serializer_pipe #(.DATA_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
      );

      assign tap_valid[gi] = bus.dout_valid;
      assign tap_dout[gi]  = bus.dout;
      assign tap_fs[gi]    = bus.frame_start;
      assign tap_und[gi]   = bus.underrun;
      assign tap_ready[gi] = bus.din_ready;

      // Model: bits still to appear on the line for the current word, plus an optional buffered word.
      bit           cur_q[$];
      int           pos       = 0;
      logic [W-1:0] hold_word = '0;
      logic         hold_ord  = 1'b0;
      logic         hold_full = 1'b0;
      logic         und_exp   = 1'b0;

      always @(posedge clock or posedge reset) begin : model
        bit word_end;
        bit take;
        bit acc;
        if (reset) begin
          cur_q.delete();
          pos       = 0;
          hold_full = 1'b0;
          und_exp   = 1'b0;
        end else begin
          word_end = (cur_q.size() <= 1);
          take     = word_end && enable && hold_full;
          acc      = din_valid && (!hold_full || take);
          und_exp  = (cur_q.size() == 1) && enable && !hold_full;
          if (cur_q.size() > 0) begin
            void'(cur_q.pop_front());
            pos++;
          end
          if (take) begin
            cur_q.delete();
            for (int i = 0; i < W; i++)
              cur_q.push_back(hold_ord ? hold_word[W-1-i] : hold_word[i]);
            pos       = 0;
            hold_full = 1'b0;
          end
          if (acc) begin
            hold_word = stim_din[W-1:0];
            hold_ord  = msb_first;
            hold_full = 1'b1;
          end
        end
      end

      always @(negedge clock) begin : compare
        #1;
        chk($sformatf("w%0d dout_valid", W), bus.dout_valid, cur_q.size() > 0);
        chk($sformatf("w%0d dout", W), bus.dout, (cur_q.size() > 0) ? cur_q[0] : 1'b0);
        chk($sformatf("w%0d frame_start", W), bus.frame_start, (cur_q.size() > 0) && (pos == 0));
        chk($sformatf("w%0d underrun", W), bus.underrun, und_exp);
        chk($sformatf("w%0d din_ready", W), bus.din_ready,
            !hold_full || ((cur_q.size() <= 1) && enable));
      end
    end
  endgenerate

  // Running record of the 16-bit instance's line activity; the main sequence reads deltas from it.
  logic [63:0] cap_vec = '0;
  int cap_n = 0, fs_n = 0, und_n = 0;
  int b_cap = 0, b_fs = 0, b_und = 0;

  always @(negedge clock) begin
    #1;
    if (tap_valid[0]) begin
      cap_vec = {cap_vec[62:0], tap_dout[0]};
      cap_n++;
    end
    if (tap_fs[0])  fs_n++;
    if (tap_und[0]) und_n++;
  end

  task automatic mark();
    b_cap = cap_n;
    b_fs  = fs_n;
    b_und = und_n;
  endtask

  task automatic send(input logic [63:0] w, input logic ord);
    @(negedge clock);
    stim_din = w; msb_first = ord; din_valid = 1'b1;
    @(negedge clock);
    din_valid = 1'b0; stim_din = 64'hDEAD_BEEF_0BAD_F00D; msb_first = ~ord;
  endtask

  task automatic send2(input logic [63:0] w1, input logic o1, input logic [63:0] w2, input logic o2);
    @(negedge clock);
    stim_din = w1; msb_first = o1; din_valid = 1'b1;
    @(negedge clock);
    stim_din = w2; msb_first = o2;
    @(negedge clock);
    din_valid = 1'b0; stim_din = 64'h1357_9BDF_2468_ACE0; msb_first = ~o2;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock); #2;
    chk("reset dout_valid", tap_valid[0], 1'b0);
    chk("reset dout", tap_dout[0], 1'b0);
    chk("reset frame_start", tap_fs[0], 1'b0);
    chk("reset underrun", tap_und[0], 1'b0);
    chk("reset din_ready", tap_ready[0], 1'b1);

    // MSB first
    mark();
    send(64'hA5C3, 1'b1);
    repeat (20) @(negedge clock); #2;
    chk("s1 bit count", cap_n - b_cap, 16);
    chk("s1 stream", cap_vec[15:0], 16'hA5C3);
    chk("s1 frame_start count", fs_n - b_fs, 1);
    chk("s1 underrun count", und_n - b_und, 1);
    chk("s1 idle", tap_valid[0], 1'b0);

    // LSB first
    mark();
    send(64'hA5C3, 1'b0);
    repeat (20) @(negedge clock); #2;
    chk("s2 bit count", cap_n - b_cap, 16);
    chk("s2 stream", cap_vec[15:0], 16'hC3A5);
    chk("s2 underrun count", und_n - b_und, 1);

    // Back-to-back words, gapless
    mark();
    send2(64'hFFFF, 1'b1, 64'h0000, 1'b1);
    #2;
    chk("s3 din_ready while full", tap_ready[0], 1'b0);
    repeat (40) @(negedge clock); #2;
    chk("s3 bit count", cap_n - b_cap, 32);
    chk("s3 stream", cap_vec[31:0], 32'hFFFF_0000);
    chk("s3 frame_start count", fs_n - b_fs, 2);
    chk("s3 underrun count", und_n - b_und, 1);

    // enable low at word end: no underrun
    mark();
    send(64'h5A5A, 1'b1);
    @(negedge clock);
    enable = 1'b0;
    repeat (25) @(negedge clock); #2;
    chk("s4 bit count", cap_n - b_cap, 16);
    chk("s4 stream", cap_vec[15:0], 16'h5A5A);
    chk("s4 underrun count", und_n - b_und, 0);
    @(negedge clock);
    enable = 1'b1;

    // enable dropped mid-word with a word buffered
    mark();
    send2(64'h1234, 1'b1, 64'h00F0, 1'b0);
    repeat (5) @(negedge clock);
    enable = 1'b0;
    repeat (30) @(negedge clock); #2;
    chk("s5 first word count", cap_n - b_cap, 16);
    chk("s5 first word", cap_vec[15:0], 16'h1234);
    chk("s5 held idle", tap_valid[0], 1'b0);
    chk("s5 held din_ready", tap_ready[0], 1'b0);
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock); #2;
    chk("s5 restart valid", tap_valid[0], 1'b1);
    chk("s5 restart frame_start", tap_fs[0], 1'b1);
    repeat (20) @(negedge clock); #2;
    chk("s5 total count", cap_n - b_cap, 32);
    chk("s5 second word", cap_vec[15:0], 16'h0F00);
    chk("s5 underrun count", und_n - b_und, 1);

    // reset mid-word with a buffered word
    send2(64'h1234, 1'b1, 64'h00F0, 1'b0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("s6 reset dout_valid", tap_valid[0], 1'b0);
    chk("s6 reset din_ready", tap_ready[0], 1'b1);
    chk("s6 reset dout", tap_dout[0], 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mark();
    repeat (25) @(negedge clock); #2;
    chk("s6 no bits after reset", cap_n - b_cap, 0);
    chk("s6 no underrun after reset", und_n - b_und, 0);

    mark();
    send(64'hA5C3, 1'b1);
    repeat (20) @(negedge clock); #2;
    chk("s6 recovery stream", cap_vec[15:0], 16'hA5C3);
    chk("s6 recovery count", cap_n - b_cap, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
